// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and single-port memory bus seen by the
// arbiter. The arbiter connects through the slave modport. The CPU/memory
// side connects through the master modport.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_rdata, if_ready,
        output d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_rdata, if_ready,
        input  d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a load/store data port. Data normally wins. A streak counter forces a
// fetch grant after MAX_STREAK back-to-back data grants so fetch cannot starve.
// One transaction runs at a time: IDLE -> ACCESS -> WAIT (LATENCY cycles) -> RESP.
module mem_arbiter #(
    parameter int LATENCY    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          clr,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_DATA,
        OWN_FETCH
    } owner_t;

    localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);
    localparam logic [3:0] WaitLoad  = 4'(LATENCY - 1);

    state_t      state_q,   state_d;
    owner_t      owner_q,   owner_d;
    logic [31:0] addr_q,    addr_d;
    logic        we_q,      we_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  streak_q,  streak_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic        cancel_q,  cancel_d;
    logic [31:0] ifRdata_q, ifRdata_d;
    logic [31:0] dRdata_q,  dRdata_d;

    logic fetchValid;
    logic grantData;
    logic grantFetch;

    // A flushed fetch is not a candidate. Data wins unless the streak limit forces fetch.
    always_comb begin
        fetchValid = bus.if_req && !bus.if_flush;
        grantData  = bus.d_req && !(fetchValid && (streak_q == MaxStreak));
        grantFetch = !grantData && fetchValid;
    end

    // State and datapath registers. clr is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            owner_q   <= OWN_DATA;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            streak_q  <= '0;
            waitCnt_q <= '0;
            cancel_q  <= 1'b0;
            ifRdata_q <= '0;
            dRdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            streak_q  <= streak_d;
            waitCnt_q <= waitCnt_d;
            cancel_q  <= cancel_d;
            ifRdata_q <= ifRdata_d;
            dRdata_q  <= dRdata_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, count latency in WAIT, capture read data.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        streak_d  = streak_q;
        waitCnt_d = waitCnt_q;
        cancel_d  = cancel_q;
        ifRdata_d = ifRdata_q;
        dRdata_d  = dRdata_q;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (grantData) begin
                    owner_d = OWN_DATA;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    if (bus.if_req) begin
                        streak_d = (streak_q == MaxStreak) ? MaxStreak : streak_q + 4'd1;
                    end else begin
                        streak_d = '0;
                    end
                    state_d = ACCESS;
                end else if (grantFetch) begin
                    owner_d  = OWN_FETCH;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    streak_d = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                waitCnt_d = WaitLoad;
                state_d   = WAIT;
            end
            WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    if (owner_q == OWN_DATA && !we_q) begin
                        dRdata_d = bus.mem_rdata;
                    end
                    if (owner_q == OWN_FETCH && !cancel_q && !bus.if_flush) begin
                        ifRdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                cancel_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush during a fetch lets the memory access finish but marks the result as dead.
        if ((state_q == ACCESS || state_q == WAIT) && owner_q == OWN_FETCH && bus.if_flush) begin
            cancel_d = 1'b1;
        end
    end

    // Outputs decode from the current state. Address and write data hold the latched values.
    always_comb begin
        bus.mem_en    = (state_q == ACCESS);
        bus.mem_we    = (state_q == ACCESS) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_ready  = (state_q == RESP) && (owner_q == OWN_FETCH) && !cancel_q && !bus.if_flush;
        bus.d_ready   = (state_q == RESP) && (owner_q == OWN_DATA);
        bus.if_rdata  = ifRdata_q;
        bus.d_rdata   = dRdata_q;
        bus.busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Three instances cover LATENCY 1, 2 and 3.
// They share clock and reset. A small per-instance model presents the read data
// on mem_rdata only in the cycle LATENCY cycles after mem_en. In every other
// cycle it drives a poison value, so a capture in the wrong cycle shows up.
module tb_mem_arbiter;

    logic clk;
    logic clr;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if b1();
    mem_arbiter_if b2();
    mem_arbiter_if b3();

    mem_arbiter #(.LATENCY(1), .MAX_STREAK(4)) u1 (.clk(clk), .clr(clr), .bus(b1));
    mem_arbiter #(.LATENCY(2), .MAX_STREAK(4)) u2 (.clk(clk), .clr(clr), .bus(b2));
    mem_arbiter #(.LATENCY(3), .MAX_STREAK(4)) u3 (.clk(clk), .clr(clr), .bus(b3));

    logic [31:0] rdv1, rdv2, rdv3;
    logic [3:0]  vp1, vp2, vp3;

    // Delay mem_en through a shift register to find the cycle where read data is valid
    always @(posedge clk) begin
        vp1 <= {vp1[2:0], b1.mem_en};
        vp2 <= {vp2[2:0], b2.mem_en};
        vp3 <= {vp3[2:0], b3.mem_en};
    end

    assign b1.mem_rdata = vp1[0] ? rdv1 : 32'hBAD0_BAD0;
    assign b2.mem_rdata = vp2[1] ? rdv2 : 32'hBAD0_BAD0;
    assign b3.mem_rdata = vp3[2] ? rdv3 : 32'hBAD0_BAD0;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a test wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.if_flush = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.if_flush = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        clearInputs();
        rdv1 = 32'h0; rdv2 = 32'h0; rdv3 = 32'h0;
        vp1 = 0; vp2 = 0; vp3 = 0;
        tick();
        tick();
        checks++; if (b1.busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", b1.busy); end
        checks++; if (b1.mem_en !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mem_en: got %b, expected 0", b1.mem_en); end
        checks++; if (b1.mem_we !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mem_we: got %b, expected 0", b1.mem_we); end
        checks++; if (b1.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0", b1.mem_addr); end
        checks++; if (b1.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h, expected 0", b1.mem_wdata); end
        checks++; if (b1.if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_rdata: got %h, expected 0", b1.if_rdata); end
        checks++; if (b1.d_rdata !== 32'h0)  begin errors++; $display("[TB] FAIL reset_d_rdata: got %h, expected 0", b1.d_rdata); end
        checks++; if (b1.if_ready !== 1'b0 || b1.d_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got if=%b d=%b, expected 0 0", b1.if_ready, b1.d_ready);
        end
        clr = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        b1.if_addr = 32'h10;
        b1.if_req  = 1'b1;
        rdv1       = 32'hDEAD_BEEF;
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_t0_busy: got %b, expected 0", b1.busy); end
        tick(); // T1
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_addr !== 32'h10) begin
            errors++; $display("[TB] FAIL fetch_t1_access: got en=%b addr=%h, expected en=1 addr=00000010", b1.mem_en, b1.mem_addr);
        end
        checks++; if (b1.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_t1_we: got %b, expected 0", b1.mem_we); end
        tick(); // T2
        checks++; if (b1.mem_en !== 1'b0 || b1.if_ready !== 1'b0 || b1.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL fetch_t2_wait: got en=%b rdy=%b busy=%b, expected 0 0 1", b1.mem_en, b1.if_ready, b1.busy);
        end
        tick(); // T3
        checks++; if (b1.if_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_t3_ready: got %b, expected 1", b1.if_ready); end
        checks++; if (b1.if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL fetch_t3_rdata: got %h, expected deadbeef", b1.if_rdata); end
        b1.if_req = 1'b0;
        tick(); // T4
        checks++; if (b1.if_ready !== 1'b0 || b1.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL fetch_t4_done: got rdy=%b busy=%b, expected 0 0", b1.if_ready, b1.busy);
        end
    endtask

    task automatic test_store_load();
        // Store. Memory presents junk during the store so that a wrong capture would change d_rdata.
        b1.d_we = 1'b1; b1.d_addr = 32'h20; b1.d_wdata = 32'h1234_5678; b1.d_req = 1'b1;
        rdv1 = 32'hCAFE_F00D;
        tick(); // T1
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_we !== 1'b1 || b1.mem_addr !== 32'h20 || b1.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL store_access: got en=%b we=%b addr=%h wdata=%h, expected 1 1 00000020 12345678",
                               b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
        end
        tick(); // T2
        checks++; if (b1.mem_we !== 1'b0 || b1.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL store_hold: got we=%b wdata=%h, expected 0 12345678", b1.mem_we, b1.mem_wdata);
        end
        tick(); // T3
        checks++; if (b1.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL store_ready: got %b, expected 1", b1.d_ready); end
        checks++; if (b1.d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL store_rdata_kept: got %h, expected 00000000", b1.d_rdata); end
        b1.d_req = 1'b0;
        tick();
        checks++; if (b1.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL store_ready_pulse: got %b, expected 0", b1.d_ready); end
        // Load from the same address
        b1.d_we = 1'b0; b1.d_req = 1'b1;
        rdv1 = 32'h1234_5678;
        tick(); // T1
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_we !== 1'b0) begin
            errors++; $display("[TB] FAIL load_access: got en=%b we=%b, expected 1 0", b1.mem_en, b1.mem_we);
        end
        tick();
        tick(); // T3
        checks++; if (b1.d_ready !== 1'b1 || b1.d_rdata !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL load_result: got rdy=%b rdata=%h, expected 1 12345678", b1.d_ready, b1.d_rdata);
        end
        b1.d_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] expAddr [6];
        logic [3:0]  expStreak [6];
        expAddr   = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
        expStreak = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
        clr = 1'b0;
        tick();
        clr = 1'b1;
        b1.if_addr = 32'h100; b1.if_req = 1'b1;
        b1.d_addr = 32'h200; b1.d_we = 1'b0; b1.d_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 20 && b1.mem_en !== 1'b1; k++) tick();
            checks++; if (b1.mem_en !== 1'b1) begin errors++; $display("[TB] FAIL starve_grant%0d_timeout: got en=%b, expected 1", g, b1.mem_en); end
            checks++; if (b1.mem_addr !== expAddr[g]) begin
                errors++; $display("[TB] FAIL starve_grant%0d_addr: got %h, expected %h", g, b1.mem_addr, expAddr[g]);
            end
            checks++; if (u1.streak_q !== expStreak[g]) begin
                errors++; $display("[TB] FAIL starve_grant%0d_streak: got %0d, expected %0d", g, u1.streak_q, expStreak[g]);
            end
            tick();
        end
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        for (int k = 0; k < 20 && b1.busy !== 1'b0; k++) tick();
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("[TB] FAIL starve_drain: got busy=%b, expected 0", b1.busy); end
    endtask

    task automatic test_flush_idle();
        int enCount = 0;
        b1.if_addr = 32'h60; b1.if_req = 1'b1; b1.if_flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (b1.mem_en === 1'b1 || b1.busy === 1'b1) enCount++;
        end
        checks++; if (enCount !== 0) begin errors++; $display("[TB] FAIL flush_idle_blocked: got %0d busy cycles, expected 0", enCount); end
        b1.if_flush = 1'b0;
        rdv1 = 32'h6060_6060;
        tick();
        checks++; if (b1.mem_en !== 1'b1 || b1.mem_addr !== 32'h60) begin
            errors++; $display("[TB] FAIL flush_idle_release: got en=%b addr=%h, expected 1 00000060", b1.mem_en, b1.mem_addr);
        end
        tick();
        tick();
        checks++; if (b1.if_ready !== 1'b1 || b1.if_rdata !== 32'h6060_6060) begin
            errors++; $display("[TB] FAIL flush_idle_fetch: got rdy=%b rdata=%h, expected 1 60606060", b1.if_ready, b1.if_rdata);
        end
        b1.if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        b1.d_we = 1'b0; b1.d_addr = 32'h30; b1.d_req = 1'b1;
        rdv1 = 32'h0000_0077;
        tick(); // T1
        checks++; if (b1.mem_en !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_access: got %b, expected 1", b1.mem_en); end
        tick(); // T2 (WAIT)
        clr = 1'b0;
        tick(); // T3
        checks++; if (b1.busy !== 1'b0 || b1.mem_en !== 1'b0 || b1.d_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_idle: got busy=%b en=%b rdy=%b, expected 0 0 0", b1.busy, b1.mem_en, b1.d_ready);
        end
        checks++; if (b1.mem_addr !== 32'h0 || b1.d_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL rstmid_clear: got addr=%h rdata=%h, expected 0 0", b1.mem_addr, b1.d_rdata);
        end
        clr = 1'b1;
        b1.d_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b1.d_ready === 1'b1 || b1.if_ready === 1'b1 || b1.mem_en === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL rstmid_no_pulse: got %0d active cycles, expected 0", stray); end
    endtask

    task automatic test_flush_inflight();
        int enCount = 0;
        int rdyCount = 0;
        b3.if_addr = 32'h40; b3.if_req = 1'b1;
        rdv3 = 32'h55AA_55AA;
        tick(); // T1
        if (b3.mem_en === 1'b1) enCount++;
        tick(); // T2
        b3.if_flush = 1'b1; b3.if_req = 1'b0;
        for (int c = 2; c < 6; c++) begin
            if (b3.mem_en === 1'b1) enCount++;
            if (b3.if_ready === 1'b1) rdyCount++;
            if (c == 5) begin
                checks++; if (b3.busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_t5_busy: got %b, expected 1", b3.busy); end
            end
            tick();
            if (c == 2) b3.if_flush = 1'b0;
        end
        // T6
        checks++; if (enCount !== 1) begin errors++; $display("[TB] FAIL flush_mem_en_count: got %0d, expected 1", enCount); end
        checks++; if (rdyCount !== 0) begin errors++; $display("[TB] FAIL flush_no_ready: got %0d pulses, expected 0", rdyCount); end
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_t6_idle: got busy=%b, expected 0", b3.busy); end
        checks++; if (b3.if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL flush_rdata_kept: got %h, expected 00000000", b3.if_rdata); end
    endtask

    task automatic test_back_to_back();
        int en1 = -1;
        int en2 = -1;
        int rdy1 = -1;
        int doublePulse = 0;
        logic prevReady = 1'b0;
        logic [31:0] rdataAtReady = 32'h0;
        b2.d_we = 1'b0; b2.d_addr = 32'h50; b2.d_req = 1'b1;
        rdv2 = 32'hA5A5_0001;
        for (int c = 0; c < 14; c++) begin
            if (b2.mem_en === 1'b1) begin
                if (en1 < 0) en1 = c;
                else if (en2 < 0) en2 = c;
            end
            if (b2.d_ready === 1'b1) begin
                if (rdy1 < 0) begin
                    rdy1 = c;
                    rdataAtReady = b2.d_rdata;
                end
                if (prevReady) doublePulse++;
            end
            prevReady = b2.d_ready;
            tick();
        end
        checks++; if (en2 - en1 !== 5) begin errors++; $display("[TB] FAIL b2b_gap: got %0d cycles, expected 5", en2 - en1); end
        checks++; if (rdy1 - en1 !== 3) begin errors++; $display("[TB] FAIL b2b_latency: got %0d cycles, expected 3", rdy1 - en1); end
        checks++; if (doublePulse !== 0) begin errors++; $display("[TB] FAIL b2b_single_pulse: got %0d long pulses, expected 0", doublePulse); end
        checks++; if (rdataAtReady !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL b2b_rdata: got %h, expected a5a50001", rdataAtReady); end
        b2.d_req = 1'b0;
        for (int k = 0; k < 12 && b2.busy !== 1'b0; k++) tick();
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got busy=%b, expected 0", b2.busy); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_flush_idle();
        test_reset_mid();
        test_flush_inflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
